// File: rtl/alu_mdu_if.sv
// Operand/result bundle between the ALU/MDU and its requester.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUOp;
    logic             start;
    logic [WIDTH-1:0] C;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output A, B, ALUOp, start,
        input  C, zero, overflow, busy, done, hi, lo
    );

    modport slave (
        input  A, B, ALUOp, start,
        output C, zero, overflow, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// MIPS-style ALU with a multi-cycle multiply/divide unit owning the HI/LO registers.
module alu_mdu #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mdu_if.slave  bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             sgn;
    logic             done_r;
    logic [WIDTH-1:0] a_cap, b_cap;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             launch_mul, launch_div, commit;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic        [WIDTH-1:0] sum, diff, c;
    logic                    ovf;

    function automatic logic add_ovf(input logic [WIDTH-1:0] x, y, r);
        return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic [2*WIDTH-1:0] mul_res(input logic [WIDTH-1:0] x, y,
                                                   input logic s);
        logic signed [2*WIDTH-1:0] xs, ys;
        xs = s ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ys = s ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return xs * ys;
    endfunction

    // Magnitude divide then fix signs: gives truncation toward zero and
    // makes most-negative / -1 wrap back to most-negative with zero remainder.
    function automatic logic [2*WIDTH-1:0] div_res(input logic [WIDTH-1:0] x, y,
                                                   input logic s);
        logic             nx, ny;
        logic [WIDTH-1:0] mx, my, q, r;
        nx = s & x[WIDTH-1];
        ny = s & y[WIDTH-1];
        mx = nx ? -x : x;
        my = ny ? -y : y;
        q  = mx / my;
        r  = mx % my;
        if (nx ^ ny) q = -q;
        if (nx)      r = -r;
        return {r, q};
    endfunction

    assign a_s  = bus.A;
    assign b_s  = bus.B;
    assign sum  = bus.A + bus.B;
    assign diff = bus.A - bus.B;

    always_comb begin
        c   = '0;
        ovf = 1'b0;
        case (bus.ALUOp)
            4'd0:    begin c = sum;  ovf = add_ovf(bus.A, bus.B, sum);   end
            4'd1:    begin c = diff; ovf = add_ovf(bus.A, ~bus.B, diff); end
            4'd2:    c = bus.A | bus.B;
            4'd3:    c = bus.A & bus.B;
            4'd4:    c = bus.A ^ bus.B;
            4'd5:    c = ~(bus.A | bus.B);
            4'd6:    c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'd7:    c = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            4'd14:   c = hi_r;
            4'd15:   c = lo_r;
            default: c = '0;
        endcase
    end

    assign bus.C        = c;
    assign bus.zero     = (bus.A == bus.B);
    assign bus.overflow = ovf;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        launch_mul = 1'b0;
        launch_div = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && (bus.ALUOp == 4'd8 || bus.ALUOp == 4'd9)) begin
                    launch_mul = 1'b1;
                    next_state = MUL;
                end else if (bus.start && (bus.ALUOp == 4'd10 || bus.ALUOp == 4'd11)) begin
                    launch_div = 1'b1;
                    next_state = DIV;
                end
            end
            MUL, DIV: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Captured operands are pure data and carry no reset.
    always_ff @(posedge clk) begin
        if (launch_mul || launch_div) begin
            a_cap <= bus.A;
            b_cap <= bus.B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            sgn    <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= commit;
            if (launch_mul) begin
                cnt <= CNT_W'(MUL_LAT);
                sgn <= ~bus.ALUOp[0];
            end else if (launch_div) begin
                cnt <= CNT_W'(DIV_LAT);
                sgn <= ~bus.ALUOp[0];
            end else if (state != IDLE) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit && state == MUL) begin
                {hi_r, lo_r} <= mul_res(a_cap, b_cap, sgn);
            end else if (commit && state == DIV && b_cap != '0) begin
                {hi_r, lo_r} <= div_res(a_cap, b_cap, sgn);
            end
            if (state == IDLE && bus.start && bus.ALUOp == 4'd12) hi_r <= bus.A;
            if (state == IDLE && bus.start && bus.ALUOp == 4'd13) lo_r <= bus.A;
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: combinational ALU checks plus queued HI/LO results.
module tb_alu_mdu;
    localparam int W       = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    alu_mdu_if #(.WIDTH(W)) bus();

    alu_mdu #(.WIDTH(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_c(input logic [3:0] op, input logic [31:0] a, b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a | b;
            4'd3:  return a & b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd14: return m_hi;
            4'd15: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_ovf(input logic [3:0] op, input logic [31:0] a, b);
        longint s;
        if (op == 4'd0)      s = longint'($signed(a)) + longint'($signed(b));
        else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(b));
        else return 1'b0;
        return s != longint'($signed(s[31:0]));
    endfunction

    function automatic logic [63:0] exp_mdu(input logic [3:0] op, input logic [31:0] a, b);
        longint p;
        int     q, r;
        case (op)
            4'd8: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            4'd9: return {32'd0, a} * {32'd0, b};
            4'd10: begin
                if (b == 32'd0) return {m_hi, m_lo};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            4'd11: begin
                if (b == 32'd0) return {m_hi, m_lo};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic comb_vec(input logic [3:0] op, input logic [31:0] a, b);
        bus.ALUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b0;
        #1;
        check($sformatf("C op%0d", op), bus.C, model_c(op, a, b));
        check($sformatf("zero op%0d", op), bus.zero, (a == b));
        check($sformatf("ovf op%0d", op), bus.overflow, model_ovf(op, a, b));
    endtask

    task automatic launch(input logic [3:0] op, input logic [31:0] a, b);
        bus.ALUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        exp_q.push_back(exp_mdu(op, a, b));
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        bus.ALUOp = op;
        bus.A     = a;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        if (op == 4'd12) m_hi = a;
        else             m_lo = a;
        check("mt_busy", bus.busy, 1'b0);
    endtask

    task automatic wait_done(input int lat, input string tag);
        int n = 0;
        int g = 0;
        while (!bus.done && g < 200) begin
            if (bus.busy) n++;
            cycle();
            g++;
        end
        if (!bus.done) begin
            check({tag, "_timeout"}, bus.done, 1'b1);
        end else begin
            check({tag, "_busy_cycles"}, n, lat);
            cycle();
            check({tag, "_done_1cyc"}, bus.done, 1'b0);
        end
    endtask

    // Scoreboard side: every done pulse retires the oldest pending HI/LO result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            check("done_busy", bus.busy, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", bus.done, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("hi", bus.hi, e[63:32]);
                check("lo", bus.lo, e[31:0]);
                m_hi = e[63:32];
                m_lo = e[31:0];
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.ALUOp = '0;
        bus.start = 1'b0;
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);

        rst_n = 1'b1;
        move_to(4'd12, 32'h0000_ABCD);
        comb_vec(4'd14, 32'd0, 32'd1);
        move_to(4'd13, 32'h5555_0001);
        comb_vec(4'd15, 32'd3, 32'd3);

        comb_vec(4'd0, 32'h7FFF_FFFF, 32'd1);
        comb_vec(4'd1, 32'd5, 32'd5);
        comb_vec(4'd1, 32'h8000_0000, 32'd1);
        comb_vec(4'd0, 32'hFFFF_FFFF, 32'd1);
        comb_vec(4'd6, 32'hFFFF_FFF0, 32'd2);
        comb_vec(4'd7, 32'hFFFF_FFF0, 32'd2);
        comb_vec(4'd5, 32'h0F0F_0000, 32'h0000_F0F0);
        comb_vec(4'd8, 32'd9, 32'd9);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 4 == 0) ? ra : $urandom;
            comb_vec(4'($urandom_range(0, 7)), ra, rb);
        end

        bus.ALUOp = 4'd0;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        check("alu_start_busy", bus.busy, 1'b0);
        check("alu_start_hi", bus.hi, m_hi);

        launch(4'd8, 32'hFFFF_FFFF, 32'd2);
        wait_done(MUL_LAT, "mult");
        launch(4'd9, 32'hFFFF_FFFF, 32'd2);
        wait_done(MUL_LAT, "multu");
        launch(4'd10, 32'hFFFF_FFF9, 32'd2);
        wait_done(DIV_LAT, "div");
        launch(4'd11, 32'd7, 32'd0);
        wait_done(DIV_LAT, "divu0");
        launch(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(DIV_LAT, "divmin");
        launch(4'd11, 32'd100, 32'd7);
        wait_done(DIV_LAT, "divu");

        launch(4'd8, 32'h0001_0001, 32'h0001_0001);
        bus.ALUOp = 4'd13;
        bus.A     = 32'h0000_1234;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        comb_vec(4'd15, 32'd1, 32'd2);
        wait_done(MUL_LAT - 1, "mult_busy");
        comb_vec(4'd15, 32'd1, 32'd2);

        launch(4'd10, 32'd100, 32'd3);
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        check("arst_done", bus.done, 1'b0);
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        rst_n = 1'b1;
        launch(4'd8, 32'd6, 32'hFFFF_FFF9);
        wait_done(MUL_LAT, "mult_after_rst");

        cycle();
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
